// File: rtl/spi_hex_uart_tx.sv
// Turns each byte from the SPI read stage into a UART "HH\r\n" line (8N1, idle high).
// One byte is in flight at a time; strobes that arrive while busy are dropped and flagged.
module spi_hex_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       ready,
    output logic       tx,
    output logic       frame_done,
    output logic       overrun
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [BAUD_W-1:0] baud_r;
    logic [BAUD_W-1:0] baud_s;
    logic [2:0]        bit_r;
    logic [2:0]        bit_s;
    logic [1:0]        char_r;
    logic [1:0]        char_s;
    logic [7:0]        byte_r;
    logic [7:0]        byte_s;
    logic              done_s;
    logic              tx_s;
    logic              ready_s;
    logic              overrun_s;
    logic [7:0]        cur_char_s;
    logic              tx_r;
    logic              ready_r;
    logic              done_r;
    logic              overrun_r;
    logic              baud_end_s;

    // ASCII hex digit, uppercase
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] res;
        if (nib < 4'd10) begin
            res = 8'h30 + {4'h0, nib};
        end else begin
            res = 8'h37 + {4'h0, nib};
        end
        return res;
    endfunction

    function automatic logic [7:0] frame_char(input logic [7:0] b, input logic [1:0] idx);
        logic [7:0] res;
        case (idx)
            2'd0:    res = hex_ascii(b[7:4]);
            2'd1:    res = hex_ascii(b[3:0]);
            2'd2:    res = 8'h0D;
            2'd3:    res = 8'h0A;
            default: res = 8'h0A;
        endcase
        return res;
    endfunction

    assign baud_end_s = (baud_r == BAUD_LAST);

    // Next-state, counter and capture logic
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r;
        bit_s   = bit_r;
        char_s  = char_r;
        byte_s  = byte_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (byte_valid) begin
                    state_s = START;
                    byte_s  = byte_in;
                    baud_s  = '0;
                    bit_s   = 3'd0;
                    char_s  = 2'd0;
                end else begin
                    baud_s  = '0;
                end
            end
            START: begin
                if (baud_end_s) begin
                    baud_s  = '0;
                    bit_s   = 3'd0;
                    state_s = DATA;
                end else begin
                    baud_s  = baud_r + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_end_s) begin
                    baud_s = '0;
                    if (bit_r == 3'd7) begin
                        bit_s   = 3'd0;
                        state_s = STOP;
                    end else begin
                        bit_s   = bit_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_end_s) begin
                    baud_s = '0;
                    if (char_r == 2'd3) begin
                        char_s  = 2'd0;
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        char_s  = char_r + 2'd1;
                        state_s = START;
                    end
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                baud_s  = '0;
                bit_s   = 3'd0;
                char_s  = 2'd0;
            end
        endcase
    end

    // Output values for the upcoming cycle, derived from the next state so tx is registered
    always_comb begin
        cur_char_s = frame_char(byte_s, char_s);
        tx_s       = 1'b1;
        case (state_s)
            IDLE:    tx_s = 1'b1;
            START:   tx_s = 1'b0;
            DATA:    tx_s = cur_char_s[bit_s];
            STOP:    tx_s = 1'b1;
            default: tx_s = 1'b1;
        endcase
        ready_s = (state_s == IDLE);
        if (byte_valid && !ready_r) begin
            overrun_s = 1'b1;
        end else begin
            overrun_s = 1'b0;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r   <= IDLE;
            baud_r    <= '0;
            bit_r     <= 3'd0;
            char_r    <= 2'd0;
            byte_r    <= 8'h00;
            tx_r      <= 1'b1;
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            baud_r    <= baud_s;
            bit_r     <= bit_s;
            char_r    <= char_s;
            byte_r    <= byte_s;
            tx_r      <= tx_s;
            ready_r   <= ready_s;
            done_r    <= done_s;
            overrun_r <= overrun_s;
        end
    end

    assign tx         = tx_r;
    assign ready      = ready_r;
    assign frame_done = done_r;
    assign overrun    = overrun_r;

endmodule
